vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing generator that produces the pixel coordinates (x, y), the active-video flag (vde) and the sync pulses for the video output path.
- Sits directly upstream of the overlay/colour-mux stage. It feeds that stage x, y and vde, and feeds hsync/vsync to the TMDS/VGA output.
- Advances one pixel per clk cycle in which pix_en is high, so it can run from a faster system clock (e.g. 100 MHz with a divide-by-4 enable for 25 MHz pixels).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pix_en  in  1  pixel-advance enable (clock enable)
- x  out  10  current horizontal count, 0..H_TOTAL-1
- y  out  10  current vertical count, 0..V_TOTAL-1
- vde  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- line_start  out  1  one-clk pulse when x becomes 0
- frame_start  out  1  one-clk pulse when (x,y) becomes (0,0)

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024 (elaboration-time assertion).
- All outputs are registered; no combinational path from any input to any output.
- Internal counters h_cnt and v_cnt reset to H_TOTAL-1 and V_TOTAL-1 (the last pixel of the frame).
- Output reset values: x=0, y=0, vde=0, hsync=~SYNC_POL, vsync=~SYNC_POL, line_start=0, frame_start=0.
- Advancing edge (rst_n=1, pix_en=1):
  - h_cnt wraps H_TOTAL-1 → 0, otherwise increments by 1.
  - v_cnt increments only when h_cnt wraps, and wraps V_TOTAL-1 → 0.
  - Outputs are decoded from the new counter values, so x and y equal the new h_cnt and v_cnt in the same cycle. Latency from the advancing edge to the outputs is 0 cycles.
- The first advancing edge after reset release outputs (0,0) with vde=1, line_start=1 and frame_start=1.
- hsync = SYNC_POL when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise ~SYNC_POL.
- vsync = SYNC_POL for the whole of every line with V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise ~SYNC_POL. vsync edges therefore coincide with x=0.
- Non-advancing edge (pix_en=0):
  - x, y, vde, hsync and vsync hold their values.
  - line_start and frame_start are forced to 0. Each pulse is exactly one clk wide, regardless of the pix_en duty cycle.
- pix_en held high continuously: one pixel per clk, and a frame is 420000 clk cycles.
- Reset mid-frame: on the next edge with rst_n=0, all outputs return to their reset values and the counters return to (H_TOTAL-1, V_TOTAL-1), whatever pix_en is. rst_n has priority over pix_en.
- x and y outside the active region are raw counter values, not clamped. Downstream stages gate on vde.

Test Plan:
- Reset release with pix_en=1 constant → first edge gives x=0, y=0, vde=1, frame_start=1, line_start=1. Next edge gives x=1, frame_start=0, line_start=0.
- Run one full line with pix_en=1 → vde falls at x=640. hsync is low for exactly 96 cycles, x=656..751. x wraps 799→0 with y 0→1 and line_start=1.
- Run a full frame → frame_start pulses exactly once per 420000 cycles. vde is high for 640×480=307200 cycles. vsync is low for exactly 2×800=1600 cycles, starting at (0,490). y wraps 524→0.
- pix_en pattern 1,0,0,0 repeating → x advances once per 4 clks and outputs hold in between. line_start and frame_start stay 1 clk wide. The frame takes 1680000 clks.
- Assert rst_n=0 for one cycle at (300,200) → outputs return to their reset values. The first advancing edge afterwards gives (0,0) with frame_start=1.
- Re-parameterise SYNC_POL=1 with a small raster (H 8/2/2/2, V 4/1/1/1) → hsync is high only at x=10..11, vsync is high only on y=5, H_TOTAL=14, V_TOTAL=7 wrap points are correct.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, active-video flag and sync pulses.
// It advances one pixel per pix_en cycle, and every output is registered.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       vde,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_vde;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_line_start;
  logic       r_frame_start;

  logic       w_h_wrap;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic       w_vde_nxt;
  logic       w_hs_nxt;
  logic       w_vs_nxt;
  logic       w_ls_nxt;
  logic       w_fs_nxt;

  // Next counter position, decoded ahead so outputs align with the new count.
  always_comb begin
    w_h_wrap = (r_h_cnt == H_LAST);
    w_h_nxt  = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    w_v_nxt  = r_v_cnt;
    if (w_h_wrap) begin
      w_v_nxt = (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
    end
    w_vde_nxt = ({1'b0, w_h_nxt} < H_ACT_W) && ({1'b0, w_v_nxt} < V_ACT_W);
    w_hs_nxt  = (({1'b0, w_h_nxt} >= HS_BEG) && ({1'b0, w_h_nxt} < HS_END))
                ? SYNC_POL : ~SYNC_POL;
    w_vs_nxt  = (({1'b0, w_v_nxt} >= VS_BEG) && ({1'b0, w_v_nxt} < VS_END))
                ? SYNC_POL : ~SYNC_POL;
    w_ls_nxt  = (w_h_nxt == 10'd0);
    w_fs_nxt  = (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
  end

  // Counters rest on the last pixel so the first advance lands on (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt       <= H_LAST;
      r_v_cnt       <= V_LAST;
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_vde         <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (pix_en) begin
      r_h_cnt       <= w_h_nxt;
      r_v_cnt       <= w_v_nxt;
      r_x           <= w_h_nxt;
      r_y           <= w_v_nxt;
      r_vde         <= w_vde_nxt;
      r_hsync       <= w_hs_nxt;
      r_vsync       <= w_vs_nxt;
      r_line_start  <= w_ls_nxt;
      r_frame_start <= w_fs_nxt;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign vde         = r_vde;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a standard 640x480 instance and a tiny positive-sync raster,
// both compared every cycle against a linear-position reference model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       pix_en;
  logic [9:0] ax, ay, bx, by;
  logic       avde, ahs, avs, als, afs;
  logic       bvde, bhs, bvs, bls, bfs;

  int n_vec = 0;
  int n_err = 0;

  vga_timing_gen u_big (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .x(ax), .y(ay), .vde(avde), .hsync(ahs), .vsync(avs),
    .line_start(als), .frame_start(afs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .x(bx), .y(by), .vde(bvde), .hsync(bhs), .vsync(bvs),
    .line_start(bls), .frame_start(bfs)
  );

  // The reference tracks a single position within the frame; x and y are derived by division.
  typedef struct {
    int pos;
    int x;
    int y;
    bit vde, hs, vs, ls, fs;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, bit rn, bit pe,
                                 int ha, int hfp, int hsw, int hbp,
                                 int va, int vfp, int vsw, int vbp, bit pol);
    int ht, vt;
    mdl_t r;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    r  = m;
    if (!rn) begin
      r.pos = ht * vt - 1;
      r.x = 0; r.y = 0; r.vde = 0; r.hs = ~pol; r.vs = ~pol; r.ls = 0; r.fs = 0;
    end else if (pe) begin
      r.pos = (m.pos + 1) % (ht * vt);
      r.x   = r.pos % ht;
      r.y   = r.pos / ht;
      r.vde = (r.x < ha) && (r.y < va);
      r.hs  = (r.x >= ha + hfp && r.x < ha + hfp + hsw) ? pol : ~pol;
      r.vs  = (r.y >= va + vfp && r.y < va + vfp + vsw) ? pol : ~pol;
      r.ls  = (r.x == 0);
      r.fs  = (r.pos == 0);
    end else begin
      r.ls = 0;
      r.fs = 0;
    end
    return r;
  endfunction

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Drive on the falling edge, then compare just after the rising edge.
  task automatic step(input bit rn, input bit pe);
    @(negedge clk);
    rst_n  = rn;
    pix_en = pe;
    @(posedge clk);
    #1;
    ma = mstep(ma, rn, pe, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    mb = mstep(mb, rn, pe, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1);
    chk_eq("big.x", int'(ax), ma.x);
    chk_eq("big.y", int'(ay), ma.y);
    chk_eq("big.flags", int'({avde, ahs, avs, als, afs}),
           int'({ma.vde, ma.hs, ma.vs, ma.ls, ma.fs}));
    chk_eq("small.x", int'(bx), mb.x);
    chk_eq("small.y", int'(by), mb.y);
    chk_eq("small.flags", int'({bvde, bhs, bvs, bls, bfs}),
           int'({mb.vde, mb.hs, mb.vs, mb.ls, mb.fs}));
  endtask

  initial begin
    int hs_low, vde_hi, fs_cnt, vs_hi;
    rst_n  = 1'b0;
    pix_en = 1'b1;

    // Reset held with pix_en high.
    repeat (3) step(1'b0, 1'b1);
    chk_eq("rst.big.xy", int'({ax, ay}), 0);
    chk_eq("rst.big.flags", int'({avde, ahs, avs, als, afs}), 5'b01100);
    chk_eq("rst.small.flags", int'({bvde, bhs, bvs, bls, bfs}), 5'b00000);

    // Release: the first advance gives (0,0) with both pulses.
    step(1'b1, 1'b1);
    chk_eq("rel.big.xy", int'({ax, ay}), 0);
    chk_eq("rel.big.flags", int'({avde, ahs, avs, als, afs}), 5'b11111);
    chk_eq("rel.small.flags", int'({bvde, bhs, bvs, bls, bfs}), 5'b10011);
    step(1'b1, 1'b1);
    chk_eq("rel2.big.x", int'(ax), 1);
    chk_eq("rel2.big.pulses", int'({als, afs}), 0);

    // Continuous run: positions 2..2451.
    hs_low = 0; vde_hi = 0; fs_cnt = 0; vs_hi = 0;
    for (int i = 0; i < 2450; i++) begin
      step(1'b1, 1'b1);
      if (!ahs) hs_low++;
      if (avde) vde_hi++;
      if (bfs) fs_cnt++;
      if (bvs) vs_hi++;
    end
    chk_eq("run.big.hsync_low_cycles", hs_low, 3 * 96);
    chk_eq("run.big.vde_cycles", vde_hi, 638 + 640 + 640 + 52);
    chk_eq("run.small.frame_starts", fs_cnt, 25);
    chk_eq("run.small.vsync_high_cycles", vs_hi, 25 * 14);

    // Divide-by-4 enable.
    for (int i = 0; i < 3600; i++) step(1'b1, (i % 4) == 0);

    // Random enable with occasional reset.
    for (int i = 0; i < 20000; i++) begin
      step($urandom_range(0, 2999) != 0, $urandom_range(0, 2) != 0);
    end

    // Mid-frame reset while pix_en is low, then resume.
    step(1'b0, 1'b0);
    chk_eq("mid.rst.big.xy", int'({ax, ay}), 0);
    chk_eq("mid.rst.big.flags", int'({avde, ahs, avs, als, afs}), 5'b01100);
    step(1'b1, 1'b1);
    chk_eq("mid.rel.big.xy", int'({ax, ay}), 0);
    chk_eq("mid.rel.big.fs", int'(afs), 1);
    chk_eq("mid.rel.small.fs", int'(bfs), 1);
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
